// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared widths, FSM/owner enums and counter helper for the LC-3 memory arbiter.
package lc3_mem_pkg;
  localparam int LC3_AW = 16;
  localparam int LC3_DW = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} mem_arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} mem_owner_t;
  function automatic logic [LC3_DW-1:0] sat_inc(input logic [LC3_DW-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer moves only when a grant is taken.
module rr_arb2 import lc3_mem_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cpu_req,
  input  logic       dbg_req,
  output logic       grant,
  output mem_owner_t winner
);
  mem_owner_t last_q, last_d;
  always_comb begin
    winner = (cpu_req && dbg_req) ? (last_q == OWN_CPU ? OWN_DBG : OWN_CPU) : (dbg_req ? OWN_DBG : OWN_CPU);
    grant  = en && (cpu_req || dbg_req);
    last_d = grant ? winner : last_q;
  end
  always_ff @(posedge clk) last_q <= reset ? OWN_DBG : last_d;
endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: arbitrates CPU and debug requests onto a fixed-latency memory port.
module lc3_mem_arbiter import lc3_mem_pkg::*; #(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [LC3_AW-1:0] cpu_addr,
  input  logic [LC3_DW-1:0] cpu_wdata,
  output logic [LC3_DW-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [LC3_AW-1:0] dbg_addr,
  input  logic [LC3_DW-1:0] dbg_wdata,
  output logic [LC3_DW-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [LC3_AW-1:0] mem_addr,
  output logic [LC3_DW-1:0] mem_wdata,
  input  logic [LC3_DW-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [15:0]       cpu_grants,
  output logic [15:0]       dbg_grants
);
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("lc3_mem_arbiter: MEM_LAT must be in 1..15");
  end
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);
  mem_arb_state_t    state_q, state_d;
  mem_owner_t        owner_q, owner_d, winner;
  logic              grant, we_q, we_d, is_dbg;
  logic [3:0]        cnt_q, cnt_d;
  logic [LC3_AW-1:0] addr_q, addr_d;
  logic [LC3_DW-1:0] wdata_q, wdata_d, rd_val;
  logic [LC3_DW-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic [15:0]       cpu_grants_q, cpu_grants_d, dbg_grants_q, dbg_grants_d;
  rr_arb2 u_rr (
    .clk(clk), .reset(reset), .en(state_q == IDLE),
    .cpu_req(cpu_req), .dbg_req(dbg_req), .grant(grant), .winner(winner)
  );
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_grants_d = cpu_grants_q;
    dbg_grants_d = dbg_grants_q;
    is_dbg       = owner_q == OWN_DBG;
    rd_val       = we_q ? '0 : mem_rdata;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ACCESS;
        owner_d = winner;
        we_d    = winner == OWN_DBG ? dbg_we : cpu_we;
        addr_d  = winner == OWN_DBG ? dbg_addr : cpu_addr;
        wdata_d = winner == OWN_DBG ? dbg_wdata : cpu_wdata;
      end
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d     = RESP;
          cpu_rdata_d = is_dbg ? cpu_rdata_q : rd_val;
          dbg_rdata_d = is_dbg ? rd_val : dbg_rdata_q;
        end
      end
      RESP: begin
        state_d      = IDLE;
        cpu_grants_d = is_dbg ? cpu_grants_q : sat_inc(cpu_grants_q);
        dbg_grants_d = is_dbg ? sat_inc(dbg_grants_q) : dbg_grants_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_grants_q <= '0;
      dbg_grants_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_grants_q <= cpu_grants_d;
      dbg_grants_q <= dbg_grants_d;
    end
  end
  assign mem_en     = state_q == ACCESS;
  assign mem_we     = mem_en && we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = state_q != IDLE;
  assign owner      = owner_q == OWN_DBG;
  assign cpu_ready  = state_q == RESP && owner_q == OWN_CPU;
  assign dbg_ready  = state_q == RESP && owner_q == OWN_DBG;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_grants = cpu_grants_q;
  assign dbg_grants = dbg_grants_q;
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: randomized requesters, a memory model and a scoreboard monitor for the arbiter.
module tb_lc3_mem_arbiter;
  localparam int L = 2;
  typedef struct packed {logic we; logic [15:0] a; logic [15:0] d;} txn_t;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0, mem_rdata = '0;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, cpu_grants, dbg_grants;
  logic cpu_ready, dbg_ready, mem_en, mem_we, busy, owner;
  logic cpu1_req = 1'b0, en1_d = 1'b0;
  logic [15:0] cpu1_addr = '0, mem_rdata1 = '0;
  logic [15:0] cpu1_rdata, dbg1_rdata, mem1_addr, mem1_wdata, cpu1_grants, dbg1_grants;
  logic cpu1_ready, dbg1_ready, mem1_en, mem1_we, busy1, owner1;
  int checks = 0, errors = 0, cyc = 0, en_cyc = -100, c_rdy_cyc = 0;
  logic [15:0] ram [logic [15:0]];
  logic [15:0] emem [logic [15:0]];
  txn_t ctq[$], dtq[$];
  logic [15:0] cexp[$], dexp[$];
  logic gseq[$];
  logic [15:0] en_data = '0, c_done = '0, d_done = '0, c_last = '0, d_last = '0;
  logic last_win = 1'b1, prev_creq = 1'b0, prev_dreq = 1'b0, prev_en = 1'b0;
  bit c_pend = 0, d_pend = 0, c_ok = 1, d_ok = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lc3_mem_arbiter #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .cpu_grants(cpu_grants), .dbg_grants(dbg_grants)
  );

  lc3_mem_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu1_req), .cpu_we(1'b0), .cpu_addr(cpu1_addr), .cpu_wdata(16'h0000),
    .cpu_rdata(cpu1_rdata), .cpu_ready(cpu1_ready),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_rdata(dbg1_rdata), .dbg_ready(dbg1_ready),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_rdata(mem_rdata1),
    .busy(busy1), .owner(owner1), .cpu_grants(cpu1_grants), .dbg_grants(dbg1_grants)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] rd_ram(input logic [15:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction
  function automatic logic [15:0] rd_emem(input logic [15:0] a);
    return emem.exists(a) ? emem[a] : init_val(a);
  endfunction

  // Memory model and scoreboard; CPU and DBG use disjoint address regions so
  // expected read data is independent of the grant interleaving.
  always @(negedge clk) begin
    txn_t t;
    logic exp_o;
    if (reset) begin
      c_done = '0; d_done = '0; c_last = '0; d_last = '0; last_win = 1'b1;
    end else begin
      chk("mem_we_without_en", 32'(mem_we & ~mem_en), 32'd0);
      chk("mem_en_multi_cycle", 32'(mem_en & prev_en), 32'd0);
      chk("mem_en_while_idle", 32'(mem_en & ~busy), 32'd0);
      if (mem_en) begin
        exp_o = (prev_creq && prev_dreq) ? ~last_win : prev_dreq;
        chk("grant_owner", 32'(owner), 32'(exp_o));
        last_win = owner;
        gseq.push_back(owner);
        if (owner ? dtq.size() == 0 : ctq.size() == 0) chk("grant_without_request", 32'd1, 32'd0);
        else begin
          t = owner ? dtq[0] : ctq[0];
          chk("mem_we", 32'(mem_we), 32'(t.we));
          chk("mem_addr", 32'(mem_addr), 32'(t.a));
          chk("mem_wdata", 32'(mem_wdata), 32'(t.d));
        end
        en_data = rd_ram(mem_addr);
        if (mem_we) ram[mem_addr] = mem_wdata;
        en_cyc = cyc;
      end
      chk("both_ready", 32'(cpu_ready & dbg_ready), 32'd0);
      if (cpu_ready) begin
        chk("cpu_ready_latency", 32'(cyc), 32'(en_cyc + L + 1));
        chk("cpu_ready_owner", 32'(owner), 32'd0);
        if (cexp.size() == 0) chk("cpu_spurious_ready", 32'd1, 32'd0);
        else begin
          chk("cpu_rdata", 32'(cpu_rdata), 32'(cexp.pop_front()));
          ctq.delete(0);
        end
        c_last = cpu_rdata;
        c_done = (c_done == 16'hFFFF) ? c_done : c_done + 16'd1;
        c_rdy_cyc = cyc;
      end else chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(c_last));
      if (dbg_ready) begin
        chk("dbg_ready_latency", 32'(cyc), 32'(en_cyc + L + 1));
        chk("dbg_ready_owner", 32'(owner), 32'd1);
        if (dexp.size() == 0) chk("dbg_spurious_ready", 32'd1, 32'd0);
        else begin
          chk("dbg_rdata", 32'(dbg_rdata), 32'(dexp.pop_front()));
          dtq.delete(0);
        end
        d_last = dbg_rdata;
        d_done = (d_done == 16'hFFFF) ? d_done : d_done + 16'd1;
      end else chk("dbg_rdata_hold", 32'(dbg_rdata), 32'(d_last));
      if (!cpu_ready && !dbg_ready) begin
        chk("cpu_grants", 32'(cpu_grants), 32'(c_done));
        chk("dbg_grants", 32'(dbg_grants), 32'(d_done));
      end
    end
    prev_creq = cpu_req;
    prev_dreq = dbg_req;
    prev_en   = reset ? 1'b0 : mem_en;
    mem_rdata = (cyc == en_cyc + L) ? en_data : ~en_data;
  end

  // MEM_LAT=1 memory: data is valid only in the cycle after mem_en.
  always @(negedge clk) begin
    mem_rdata1 = en1_d ? 16'hC0DE : 16'h0BAD;
    en1_d = mem1_en;
  end

  task automatic cycle();
    logic cr, dr;
    @(negedge clk);
    cr = cpu_ready;
    dr = dbg_ready;
    @(posedge clk);
    #1;
    if (cr) begin cpu_req = 1'b0; c_pend = 0; end
    if (dr) begin dbg_req = 1'b0; d_pend = 0; end
    c_ok = !c_pend && !cr;
    d_ok = !d_pend && !dr;
  endtask

  task automatic issue_cpu(input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; c_pend = 1; c_ok = 0;
    cexp.push_back(we ? 16'h0000 : rd_emem(a));
    if (we) emem[a] = d;
    ctq.push_back(txn_t'{we, a, d});
  endtask

  task automatic issue_dbg(input logic we, input logic [15:0] a, input logic [15:0] d);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; d_pend = 1; d_ok = 0;
    dexp.push_back(we ? 16'h0000 : rd_emem(a));
    if (we) emem[a] = d;
    dtq.push_back(txn_t'{we, a, d});
  endtask

  task automatic rnd_cpu();
    issue_cpu(1'($urandom), {8'h30, 4'h0, 4'($urandom)}, 16'($urandom));
  endtask
  task automatic rnd_dbg();
    issue_dbg(1'($urandom), {8'h00, 4'h0, 4'($urandom)}, 16'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((c_pend || d_pend) && n < 300) begin cycle(); n++; end
    if (c_pend || d_pend) chk("drain_timeout", 32'd1, 32'd0);
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({tag, "_dbg_rdata"}, 32'(dbg_rdata), 32'd0);
    chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    chk({tag, "_dbg_ready"}, 32'(dbg_ready), 32'd0);
    chk({tag, "_cpu_grants"}, 32'(cpu_grants), 32'd0);
    chk({tag, "_dbg_grants"}, 32'(dbg_grants), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rk, en1_cnt, n, rc;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // MEM_LAT=1 instance: ready at T+3 with the data from the cycle after mem_en.
    @(posedge clk);
    #1 cpu1_req = 1'b1; cpu1_addr = 16'h3000;
    rk = -1; en1_cnt = 0;
    for (int k = 0; k < 10 && rk < 0; k++) begin
      @(negedge clk);
      if (mem1_en) en1_cnt++;
      if (cpu1_ready) rk = k;
    end
    @(posedge clk);
    #1 cpu1_req = 1'b0;
    chk("lat1_ready_cycle", 32'(rk), 32'd3);
    chk("lat1_rdata", 32'(cpu1_rdata), 32'hC0DE);
    chk("lat1_mem_en_cycles", 32'(en1_cnt), 32'd1);

    // CPU read at 3000 returning BEEF, then DBG write.
    ram[16'h3000] = 16'hBEEF;
    emem[16'h3000] = 16'hBEEF;
    cycle();
    issue_cpu(1'b0, 16'h3000, 16'h0000);
    wait_idle();
    chk("cpu_read_beef", 32'(cpu_rdata), 32'hBEEF);
    issue_dbg(1'b1, 16'h0010, 16'h1234);
    wait_idle();
    chk("dbg_write_rdata", 32'(dbg_rdata), 32'd0);
    chk("dbg_write_mem", 32'(rd_ram(16'h0010)), 32'h1234);

    // Both requesting right after reset: CPU, DBG, CPU, DBG; counters 2/2.
    do_reset();
    gseq.delete();
    rnd_cpu();
    rnd_dbg();
    n = 0;
    while (32'(c_done) + 32'(d_done) < 4 && n < 100) begin
      cycle(); n++;
      if (c_ok) rnd_cpu();
      if (d_ok) rnd_dbg();
    end
    chk("rr_cpu_grants", 32'(cpu_grants), 32'd2);
    chk("rr_dbg_grants", 32'(dbg_grants), 32'd2);
    chk("rr_grant_count", 32'(gseq.size() >= 4), 32'd1);
    if (gseq.size() >= 4) for (int i = 0; i < 4; i++) chk("rr_grant_order", 32'(gseq[i]), 32'(i % 2));
    wait_idle();

    // Reset during WAIT of a CPU read: aborted, then re-granted from the held req.
    issue_cpu(1'b0, 16'h3005, 16'h0000);
    cycle();
    cycle();
    reset = 1'b1;
    rc = cyc;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("abort");
    wait_idle();
    chk("abort_regrant_ready", 32'(c_rdy_cyc), 32'(rc + L + 3));

    // Saturation of the CPU grant counter.
    force dut.cpu_grants_q = 16'hFFFE;
    c_done = 16'hFFFE;
    @(posedge clk);
    #1 release dut.cpu_grants_q;
    issue_cpu(1'b0, 16'h3001, 16'h0000);
    wait_idle();
    chk("cpu_grants_ffff", 32'(cpu_grants), 32'hFFFF);
    issue_cpu(1'b1, 16'h3002, 16'h5555);
    wait_idle();
    chk("cpu_grants_sat", 32'(cpu_grants), 32'hFFFF);

    // Random traffic from both ports.
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (c_ok && $urandom_range(99) < 40) rnd_cpu();
      if (d_ok && $urandom_range(99) < 40) rnd_dbg();
    end
    wait_idle();
    chk("cpu_queue_empty", 32'(cexp.size()), 32'd0);
    chk("dbg_queue_empty", 32'(dexp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
